// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage and the D-stage decoder.
//   NPC_* : next-PC select codes driven by the decoder
//   RESET_PC_DEF / NOP_INSTR_DEF : default reset PC and bubble encoding
//   br_offset() : sign-extended, word-scaled branch displacement
package fetch_stage_pkg;

   localparam logic [2:0] NPC_SEQ   = 3'b000;
   localparam logic [2:0] NPC_BR    = 3'b001;
   localparam logic [2:0] NPC_J     = 3'b010;
   localparam logic [2:0] NPC_JR    = 3'b011;
   localparam logic [2:0] NPC_BGEAL = 3'b100;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   function automatic logic [31:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Next-PC selection for the fetch stage (purely combinational).
// Ports:
//   pc_f      : current fetch PC
//   pc_d      : PC of the instruction in IF/ID
//   instr_d   : instruction in IF/ID (branch immediate / jump index)
//   npc_sel   : decoder next-PC code
//   cmp_true  : D-stage comparator result
//   rs_val_d  : forwarded GPR[rs] for jr/jalr
//   npc       : selected next PC
module npc_calc
   import fetch_stage_pkg::*;
(
   input  logic [31:0] pc_f,
   input  logic [31:0] pc_d,
   input  logic [31:0] instr_d,
   input  logic [2:0]  npc_sel,
   input  logic        cmp_true,
   input  logic [31:0] rs_val_d,
   output logic [31:0] npc
);

   logic [31:0] pc_f_plus4;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;

   assign pc_f_plus4 = pc_f + 32'd4;
   // Branch target is relative to the delay slot (pc_d + 4), wrapping at 32 bits.
   assign br_tgt     = pc_d + 32'd4 + br_offset(instr_d[15:0]);
   assign j_tgt      = {pc_d[31:28], instr_d[25:0], 2'b00};

   always_comb begin
      npc = pc_f_plus4;
      case (npc_sel)
         NPC_BR, NPC_BGEAL: if (cmp_true) npc = br_tgt;
         NPC_J:             npc = j_tgt;
         // Register targets pass through unaligned; pc_misalign reports it after load.
         NPC_JR:            npc = rs_val_d;
         default:           npc = pc_f_plus4;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register. One architectural delay slot:
// the instruction fetched while a control instruction sits in D always
// advances into IF/ID; nothing is squashed. Stall freezes PC and IF/ID
// and suppresses any redirect until the stall drops.
// Ports:
//   clk, reset_n : core clock (rising edge), async active-low reset
//   stall        : hold PC and IF/ID this cycle
//   npc_sel      : decoder next-PC code
//   cmp_true     : comparator result for the D instruction
//   rs_val_d     : forwarded GPR[rs] (jr/jalr target)
//   imem_addr    : fetch address (PC_F)
//   imem_rdata   : instruction at imem_addr, combinational read
//   instr_d      : IF/ID instruction
//   pc_d, pc8_d  : IF/ID PC and its link address (pc_d + 8)
//   pc_misalign  : PC_F not word aligned
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic [2:0]  npc_sel,
   input  logic        cmp_true,
   input  logic [31:0] rs_val_d,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        pc_misalign
);

   logic [31:0] pc_f;
   logic [31:0] npc;

   npc_calc u_npc_calc (
      .pc_f     (pc_f),
      .pc_d     (pc_d),
      .instr_d  (instr_d),
      .npc_sel  (npc_sel),
      .cmp_true (cmp_true),
      .rs_val_d (rs_val_d),
      .npc      (npc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_f    <= RESET_PC;
         instr_d <= NOP_INSTR;
         pc_d    <= RESET_PC;
         pc8_d   <= RESET_PC + 32'd8;
      end else if (!stall) begin
         pc_f    <= npc;
         instr_d <= imem_rdata;
         pc_d    <= pc_f;
         pc8_d   <= pc_f + 32'd8;
      end
   end

   assign imem_addr   = pc_f;
   assign pc_misalign = |pc_f[1:0];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic [2:0]  npc_sel;
   logic        cmp_true;
   logic [31:0] rs_val_d;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        pc_misalign;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] imem [4096];

   always #5 clk = ~clk;

   assign imem_rdata = imem[imem_addr[13:2]];

   fetch_stage dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .stall       (stall),
      .npc_sel     (npc_sel),
      .cmp_true    (cmp_true),
      .rs_val_d    (rs_val_d),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr_d     (instr_d),
      .pc_d        (pc_d),
      .pc8_d       (pc8_d),
      .pc_misalign (pc_misalign)
   );

   typedef struct {
      logic        stall;
      logic [2:0]  sel;
      logic        cmp;
      logic [31:0] rs;
      logic [31:0] exp_pcf;
      logic [31:0] exp_pcd;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] pcf;
      logic [31:0] pcd;
      logic [31:0] instr;
      logic [31:0] pc8;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[23];

   function automatic vec_t mk(input logic st, input logic [2:0] sel, input logic cmp,
                               input logic [31:0] rs, input logic [31:0] pcf,
                               input logic [31:0] pcd);
      vec_t v;
      v.stall = st; v.sel = sel; v.cmp = cmp; v.rs = rs;
      v.exp_pcf = pcf; v.exp_pcd = pcd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input exp_t e);
      check({e.name, ".imem_addr"}, imem_addr, e.pcf);
      check({e.name, ".pc_d"}, pc_d, e.pcd);
      check({e.name, ".instr_d"}, instr_d, e.instr);
      check({e.name, ".pc8_d"}, pc8_d, e.pc8);
      check({e.name, ".misalign"}, {31'b0, pc_misalign}, {31'b0, e.mis});
   endtask

   // Drive one cycle of inputs, queue its expected IF/ID and PC state, then
   // compare after the edge. Expected instruction comes from the bench's own
   // memory image at the expected pc_d.
   task automatic apply(input vec_t v, input string name);
      exp_t e;
      stall    = v.stall;
      npc_sel  = v.sel;
      cmp_true = v.cmp;
      rs_val_d = v.rs;
      e.name  = name;
      e.pcf   = v.exp_pcf;
      e.pcd   = v.exp_pcd;
      e.instr = imem[v.exp_pcd[13:2]];
      e.pc8   = v.exp_pcd + 32'd8;
      e.mis   = |v.exp_pcf[1:0];
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         check_outputs(sb_q.pop_front());
      end
   endtask

   task automatic check_reset_values(input string name);
      exp_t e;
      e.name = name; e.pcf = 32'h3000; e.pcd = 32'h3000; e.instr = 32'h0;
      e.pc8 = 32'h3008; e.mis = 1'b0;
      check_outputs(e);
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      stall    = 1'b0;
      npc_sel  = 3'b000;
      cmp_true = 1'b0;
      rs_val_d = 32'h0;
      @(posedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) imem[i] = 32'hA500_0000 | 32'(i);
      imem[32'h3004 >> 2 & 32'hFFF] = 32'h1000_0003;  // branch, imm +3
      imem[32'h3008 >> 2 & 32'hFFF] = 32'h2222_0040;  // delay slot, imm would be +0x40
      imem[32'h3010 >> 2 & 32'hFFF] = 32'h1000_FFFF;  // branch, imm -1
      imem[32'h3020 >> 2 & 32'hFFF] = 32'h0800_0C40;  // j 0x3100

      // Reset, then three sequential fetches.
      do_reset();
      for (int n = 1; n <= 3; n++)
         apply(mk(1'b0, 3'b000, 1'b0, 32'h0, 32'h3000 + 32'(4 * n), 32'h3000 + 32'(4 * (n - 1))),
               $sformatf("seq%0d", n));

      // Main vector table.
      vecs[0]  = mk(1'b0, 3'b000, 1'b0, 32'h0,    32'h3004, 32'h3000);
      vecs[1]  = mk(1'b0, 3'b000, 1'b0, 32'h0,    32'h3008, 32'h3004);
      vecs[2]  = mk(1'b0, 3'b001, 1'b1, 32'h0,    32'h3014, 32'h3008);  // taken, delay slot enters D
      vecs[3]  = mk(1'b0, 3'b001, 1'b0, 32'h0,    32'h3018, 32'h3014);  // not taken
      vecs[4]  = mk(1'b0, 3'b011, 1'b0, 32'h3010, 32'h3010, 32'h3018);  // jr
      vecs[5]  = mk(1'b0, 3'b000, 1'b0, 32'h0,    32'h3014, 32'h3010);
      vecs[6]  = mk(1'b0, 3'b001, 1'b1, 32'h0,    32'h3010, 32'h3014);  // backward branch
      vecs[7]  = mk(1'b0, 3'b000, 1'b0, 32'h0,    32'h3014, 32'h3010);
      vecs[8]  = mk(1'b0, 3'b000, 1'b0, 32'h0,    32'h3018, 32'h3014);
      vecs[9]  = mk(1'b0, 3'b000, 1'b0, 32'h0,    32'h301C, 32'h3018);
      vecs[10] = mk(1'b0, 3'b000, 1'b0, 32'h0,    32'h3020, 32'h301C);
      vecs[11] = mk(1'b0, 3'b000, 1'b0, 32'h0,    32'h3024, 32'h3020);
      vecs[12] = mk(1'b0, 3'b010, 1'b0, 32'h0,    32'h3100, 32'h3024);  // j
      vecs[13] = mk(1'b0, 3'b011, 1'b0, 32'h3400, 32'h3400, 32'h3100);  // jr
      vecs[14] = mk(1'b0, 3'b011, 1'b0, 32'h3402, 32'h3402, 32'h3400);  // misaligned jr
      vecs[15] = mk(1'b0, 3'b000, 1'b0, 32'h0,    32'h3406, 32'h3402);
      vecs[16] = mk(1'b0, 3'b011, 1'b0, 32'h3000, 32'h3000, 32'h3406);
      vecs[17] = mk(1'b0, 3'b000, 1'b0, 32'h0,    32'h3004, 32'h3000);
      vecs[18] = mk(1'b0, 3'b101, 1'b1, 32'h0,    32'h3008, 32'h3004);  // reserved code = seq
      vecs[19] = mk(1'b0, 3'b100, 1'b1, 32'h0,    32'h3014, 32'h3008);  // bgeal taken
      vecs[20] = mk(1'b0, 3'b111, 1'b1, 32'h0,    32'h3018, 32'h3014);  // reserved code = seq
      vecs[21] = mk(1'b1, 3'b010, 1'b0, 32'h0,    32'h3018, 32'h3014);  // stall holds
      vecs[22] = mk(1'b0, 3'b000, 1'b0, 32'h0,    32'h301C, 32'h3018);

      do_reset();
      for (int i = 0; i < 23; i++) apply(vecs[i], $sformatf("vec%0d", i));

      // Pending jump held across a two-cycle stall, taken once released.
      do_reset();
      for (int n = 1; n <= 9; n++)
         apply(mk(1'b0, 3'b000, 1'b0, 32'h0, 32'h3000 + 32'(4 * n), 32'h3000 + 32'(4 * (n - 1))),
               $sformatf("pre%0d", n));
      apply(mk(1'b1, 3'b010, 1'b0, 32'h0, 32'h3024, 32'h3020), "stall1");
      apply(mk(1'b1, 3'b010, 1'b0, 32'h0, 32'h3024, 32'h3020), "stall2");
      apply(mk(1'b0, 3'b010, 1'b0, 32'h0, 32'h3100, 32'h3024), "unstall_j");

      // Asynchronous reset between edges while a taken branch sits in D.
      do_reset();
      apply(mk(1'b0, 3'b000, 1'b0, 32'h0, 32'h3004, 32'h3000), "ar_pre1");
      apply(mk(1'b0, 3'b000, 1'b0, 32'h0, 32'h3008, 32'h3004), "ar_pre2");
      npc_sel  = 3'b001;
      cmp_true = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      #2;
      reset_n = 1'b1;
      apply(mk(1'b0, 3'b000, 1'b0, 32'h0, 32'h3004, 32'h3000), "ar_post");

      // PC wrap-around at the top of the address space.
      apply(mk(1'b0, 3'b011, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3004), "wrap_load");
      apply(mk(1'b0, 3'b000, 1'b0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC), "wrap");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
